// File: rtl/fpu_pkg.sv
// Shared types and opcode lookup for the RV32F execute-stage issue controller.
// Maps each fpusel opcode to its execution class, target unit and unit sub-mode.
package fpu_pkg;

    typedef enum logic [4:0] {
        OP_FADD      = 5'h00,
        OP_FSUB      = 5'h01,
        OP_FMUL      = 5'h02,
        OP_FDIV      = 5'h03,
        OP_FSQRT     = 5'h04,
        OP_FSGNJ     = 5'h05,
        OP_FSGNJN    = 5'h06,
        OP_FSGNJX    = 5'h07,
        OP_FMIN      = 5'h08,
        OP_FMAX      = 5'h09,
        OP_FCVT_W_S  = 5'h0A,
        OP_FCVT_WU_S = 5'h0B,
        OP_FMV_X_W   = 5'h0C,
        OP_FEQ       = 5'h0D,
        OP_FLT       = 5'h0E,
        OP_FLE       = 5'h0F,
        OP_FCLASS    = 5'h10,
        OP_FCVT_S_W  = 5'h11,
        OP_FCVT_S_WU = 5'h12,
        OP_FMV_W_X   = 5'h13,
        OP_FMADD     = 5'h14,
        OP_FMSUB     = 5'h15,
        OP_FNMSUB    = 5'h16,
        OP_FNMADD    = 5'h17
    } fpu_op_e;

    localparam logic [1:0] UNIT_ADD = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd2;
    localparam logic [1:0] UNIT_CVT = 2'd3;

    localparam logic [1:0] MODE_DIV  = 2'd0;
    localparam logic [1:0] MODE_SQRT = 2'd1;
    localparam logic [1:0] MODE_F2I  = 2'd0;
    localparam logic [1:0] MODE_F2UI = 2'd1;
    localparam logic [1:0] MODE_I2F  = 2'd2;
    localparam logic [1:0] MODE_UI2F = 2'd3;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_DONE} state_e;

    typedef enum logic [1:0] {CLS_COMB, CLS_UNIT, CLS_FUSED, CLS_BAD} op_cls_e;

    typedef struct packed {
        op_cls_e    cls;
        logic [1:0] unit;
        logic [1:0] mode;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t info;
        info.cls  = CLS_BAD;
        info.unit = UNIT_ADD;
        info.mode = 2'd0;
        case (op)
            OP_FADD, OP_FSUB: begin
                info.cls = CLS_UNIT; info.unit = UNIT_ADD;
            end
            OP_FMUL: begin
                info.cls = CLS_UNIT; info.unit = UNIT_MUL;
            end
            OP_FDIV: begin
                info.cls = CLS_UNIT; info.unit = UNIT_DIV; info.mode = MODE_DIV;
            end
            OP_FSQRT: begin
                info.cls = CLS_UNIT; info.unit = UNIT_DIV; info.mode = MODE_SQRT;
            end
            OP_FCVT_W_S: begin
                info.cls = CLS_UNIT; info.unit = UNIT_CVT; info.mode = MODE_F2I;
            end
            OP_FCVT_WU_S: begin
                info.cls = CLS_UNIT; info.unit = UNIT_CVT; info.mode = MODE_F2UI;
            end
            OP_FCVT_S_W: begin
                info.cls = CLS_UNIT; info.unit = UNIT_CVT; info.mode = MODE_I2F;
            end
            OP_FCVT_S_WU: begin
                info.cls = CLS_UNIT; info.unit = UNIT_CVT; info.mode = MODE_UI2F;
            end
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX, OP_FMIN, OP_FMAX, OP_FMV_X_W,
            OP_FEQ, OP_FLT, OP_FLE, OP_FCLASS, OP_FMV_W_X: begin
                info.cls = CLS_COMB;
            end
            // Fused ops run the multiplier first; the adder pass is chained later.
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                info.cls = CLS_FUSED; info.unit = UNIT_MUL;
            end
            default: info.cls = CLS_BAD;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// RV32F execute-stage issue controller: dispatches ops to a bank of multi-cycle
// units over start/done handshakes, captures combinational results, chains fused ops.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_UNITS = 4,
    parameter int OP_W      = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                       g_clk,
    input  logic                       g_rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH-1:0]           c,
    input  logic [WIDTH-1:0]           comb_res,
    output logic [NUM_UNITS-1:0]       unit_start,
    output logic [1:0]                 unit_mode,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    input  logic [NUM_UNITS-1:0]       unit_done,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           res,
    output logic                       stall,
    output logic                       timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] NAN_W = WIDTH'(CANON_NAN);

    state_e               state_q, state_d;
    logic [1:0]           unit_q, unit_d;
    logic [1:0]           mode_q, mode_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     c_q, c_d;
    logic                 fused_q, fused_d;
    logic                 phase_q, phase_d;
    logic                 neg_prod_q, neg_prod_d;
    logic                 neg_c_q, neg_c_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 out_valid_q, out_valid_d;
    logic [NUM_UNITS-1:0] start_q, start_d;
    logic                 stall_q, stall_d;
    logic                 in_ready_q, in_ready_d;
    logic                 terr_q, terr_d;

    logic [4:0]           op5;
    op_info_t             info;
    logic                 sel_done;
    logic [WIDTH-1:0]     sel_res;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
        return {x[WIDTH-1] ^ en, x[WIDTH-2:0]};
    endfunction

    // Only the four architected units can ever be selected; reserved indices stay idle.
    function automatic logic [NUM_UNITS-1:0] onehot(input logic [1:0] u);
        logic [NUM_UNITS-1:0] v;
        for (int k = 0; k < NUM_UNITS; k++) v[k] = (k == int'(u));
        return v;
    endfunction

    assign op5  = op[4:0];
    assign info = decode_op(op5);

    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(unit_q) == k) begin
                sel_done = unit_done[k];
                sel_res  = unit_res[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        mode_d      = mode_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        c_d         = c_q;
        fused_d     = fused_q;
        phase_d     = phase_q;
        neg_prod_d  = neg_prod_q;
        neg_c_d     = neg_c_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        terr_d      = terr_q;
        out_valid_d = 1'b0;
        start_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (info.cls)
                        CLS_COMB: begin
                            res_d       = comb_res;
                            out_valid_d = 1'b1;
                        end
                        CLS_BAD: begin
                            res_d       = NAN_W;
                            out_valid_d = 1'b1;
                        end
                        default: begin
                            opa_d      = a;
                            opb_d      = neg_if(b, op5 == OP_FSUB);
                            c_d        = c;
                            fused_d    = (info.cls == CLS_FUSED);
                            phase_d    = 1'b0;
                            neg_prod_d = (op5 == OP_FNMSUB) || (op5 == OP_FNMADD);
                            neg_c_d    = (op5 == OP_FMSUB)  || (op5 == OP_FNMADD);
                            unit_d     = info.unit;
                            mode_d     = info.mode;
                            start_d    = onehot(info.unit);
                            state_d    = ST_LAUNCH;
                        end
                    endcase
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sel_done) begin
                    if (fused_q && !phase_q) begin
                        opa_d   = neg_if(sel_res, neg_prod_q);
                        opb_d   = neg_if(c_q, neg_c_q);
                        unit_d  = UNIT_ADD;
                        mode_d  = 2'd0;
                        phase_d = 1'b1;
                        start_d = onehot(UNIT_ADD);
                        state_d = ST_LAUNCH;
                    end else begin
                        res_d       = sel_res;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d       = NAN_W;
                    terr_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stall_d    = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge g_clk) begin
        if (!g_rst_n) begin
            state_q     <= ST_IDLE;
            unit_q      <= UNIT_ADD;
            mode_q      <= 2'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            fused_q     <= 1'b0;
            phase_q     <= 1'b0;
            neg_prod_q  <= 1'b0;
            neg_c_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= NAN_W;
            out_valid_q <= 1'b0;
            start_q     <= '0;
            stall_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            mode_q      <= mode_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            fused_q     <= fused_d;
            phase_q     <= phase_d;
            neg_prod_q  <= neg_prod_d;
            neg_c_q     <= neg_c_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            start_q     <= start_d;
            stall_q     <= stall_d;
            in_ready_q  <= in_ready_d;
            terr_q      <= terr_d;
        end
    end

    always_ff @(posedge g_clk) begin
        c_q <= c_d;
    end

    assign in_ready    = in_ready_q;
    assign unit_start  = start_q;
    assign unit_mode   = mode_q;
    assign unit_a      = opa_q;
    assign unit_b      = opb_q;
    assign out_valid   = out_valid_q;
    assign res         = res_q;
    assign stall       = stall_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: directed ops against behavioural unit models,
// expected results queued at issue and matched by a monitor on out_valid.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam logic [31:0] NAN = 32'h7FC0_0000;

    logic         clk;
    logic         g_rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op_i;
    logic [31:0]  a_i, b_i, c_i, comb_i;
    logic [3:0]   unit_start;
    logic [1:0]   unit_mode;
    logic [31:0]  unit_a, unit_b;
    logic [3:0]   unit_done;
    logic [127:0] unit_res;
    logic         out_valid;
    logic [31:0]  res;
    logic         stall;
    logic         timeout_err;

    logic [3:0]   done_m, spur_done;
    int           lat [4];
    logic [31:0]  rsp [4];
    int           rem [4];

    typedef struct {
        logic [3:0]  st;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [1:0]  md;
    } slog_t;

    slog_t        slog [$];
    logic [31:0]  exp_q [$];
    int           ov_cyc [$];
    int           n_chk, n_pass, ov_cnt, stall_cnt, cyc;

    assign unit_done = done_m | spur_done;
    assign unit_res  = {rsp[3], rsp[2], rsp[1], rsp[0]};

    fpu_issue_ctrl #(.WIDTH(32), .NUM_UNITS(4), .OP_W(5), .TIMEOUT(64)) dut (
        .g_clk(clk), .g_rst_n(g_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .a(a_i), .b(b_i), .c(c_i), .comb_res(comb_i),
        .unit_start(unit_start), .unit_mode(unit_mode), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_res(unit_res), .out_valid(out_valid), .res(res),
        .stall(stall), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Unit models: done pulses lat cycles after the start pulse; lat 0 never answers.
    initial begin
        done_m = '0;
        for (int k = 0; k < 4; k++) rem[k] = 0;
        forever begin
            @(negedge clk);
            done_m = '0;
            for (int k = 0; k < 4; k++) begin
                if (!g_rst_n) rem[k] = 0;
                else if (unit_start[k]) rem[k] = lat[k];
                else if (rem[k] > 0) begin
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) done_m[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (unit_start != 4'b0) slog.push_back('{unit_start, unit_a, unit_b, unit_mode});
            if (out_valid) begin
                ov_cnt++;
                ov_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else chk("res", res, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ic, input logic [31:0] icr);
        int n;
        n = 0;
        op_i = o; a_i = ia; b_i = ib; c_i = ic; comb_i = icr;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int target);
        int n;
        n = 0;
        while (ov_cnt < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("out_valid_count", ov_cnt, target);
    endtask

    task automatic prep();
        slog.delete();
        ov_cyc.delete();
        stall_cnt = 0;
    endtask

    function automatic slog_t slog_at(input int i);
        slog_t e;
        e = '{4'd0, 32'd0, 32'd0, 2'd0};
        if (i < slog.size()) e = slog[i];
        return e;
    endfunction

    initial begin
        int base;
        slog_t e;
        n_chk = 0; n_pass = 0; ov_cnt = 0; stall_cnt = 0;
        g_rst_n = 1'b0; in_valid = 1'b0; spur_done = '0;
        op_i = '0; a_i = '0; b_i = '0; c_i = '0; comb_i = '0;
        for (int k = 0; k < 4; k++) begin
            lat[k] = 0;
            rsp[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 g_rst_n = 1'b1;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, NAN);
        chk("rst_stall", stall, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_unit_a", unit_a, 0);
        chk("rst_unit_b", unit_b, 0);
        chk("rst_unit_mode", unit_mode, 0);

        // FADD 1.0 + 2.0 on a 4-cycle adder
        prep(); lat[0] = 4; rsp[0] = 32'h4040_0000; base = ov_cnt;
        exp_q.push_back(32'h4040_0000);
        send(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0);
        wait_ov(base + 1);
        e = slog_at(0);
        chk("fadd_start_count", slog.size(), 1);
        chk("fadd_start_vec", e.st, 4'b0001);
        chk("fadd_unit_a", e.ua, 32'h3F80_0000);
        chk("fadd_unit_b", e.ub, 32'h4000_0000);
        chk("fadd_stall_cycles", stall_cnt, 6);

        // FSUB flips the sign of b before launch
        prep(); lat[0] = 2; rsp[0] = 32'h3F80_0000; base = ov_cnt;
        exp_q.push_back(32'h3F80_0000);
        send(OP_FSUB, 32'h4040_0000, 32'h4000_0000, 32'h0, 32'h0);
        wait_ov(base + 1);
        e = slog_at(0);
        chk("fsub_unit_b", e.ub, 32'hC000_0000);
        chk("fsub_stall_cycles", stall_cnt, 4);

        // FMADD 2*3+1: multiplier then adder with product and c
        prep(); lat[1] = 3; rsp[1] = 32'h40C0_0000; lat[0] = 2; rsp[0] = 32'h40E0_0000; base = ov_cnt;
        exp_q.push_back(32'h40E0_0000);
        send(OP_FMADD, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0);
        wait_ov(base + 1);
        chk("fmadd_start_count", slog.size(), 2);
        e = slog_at(0);
        chk("fmadd_mul_start", e.st, 4'b0010);
        chk("fmadd_mul_a", e.ua, 32'h4000_0000);
        chk("fmadd_mul_b", e.ub, 32'h4040_0000);
        e = slog_at(1);
        chk("fmadd_add_start", e.st, 4'b0001);
        chk("fmadd_add_a", e.ua, 32'h40C0_0000);
        chk("fmadd_add_b", e.ub, 32'h3F80_0000);
        chk("fmadd_stall_cycles", stall_cnt, 8);

        // FNMADD: -(a*b) - c
        prep(); rsp[0] = 32'hC0E0_0000; base = ov_cnt;
        exp_q.push_back(32'hC0E0_0000);
        send(OP_FNMADD, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0);
        wait_ov(base + 1);
        e = slog_at(1);
        chk("fnmadd_add_a", e.ua, 32'hC0C0_0000);
        chk("fnmadd_add_b", e.ub, 32'hBF80_0000);

        // Back-to-back combinational ops, then an unknown opcode
        prep(); base = ov_cnt;
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h3F80_0000);
        exp_q.push_back(NAN);
        send(OP_FEQ, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0000_0001);
        send(OP_FMIN, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h3F80_0000);
        send(5'h1F, 32'h1234_5678, 32'h0, 32'h0, 32'hDEAD_BEEF);
        wait_ov(base + 3);
        chk("comb_consecutive", (ov_cyc.size() >= 2) ? ov_cyc[1] - ov_cyc[0] : -1, 1);
        chk("comb_stall_cycles", stall_cnt, 0);
        chk("comb_no_start", slog.size(), 0);

        // FMUL with a spurious convert-unit done during the wait
        prep(); lat[1] = 5; rsp[1] = 32'h4120_0000; rsp[3] = 32'hDEAD_BEEF; base = ov_cnt;
        exp_q.push_back(32'h4120_0000);
        send(OP_FMUL, 32'h4000_0000, 32'h40A0_0000, 32'h0, 32'h0);
        @(posedge clk); #1 spur_done = 4'b1000;
        @(posedge clk); #1 spur_done = 4'b0000;
        wait_ov(base + 1);
        chk("spurious_stall_cycles", stall_cnt, 7);

        // FSQRT selects unit 2 in sqrt mode
        prep(); lat[2] = 1; rsp[2] = 32'h4000_0000; base = ov_cnt;
        exp_q.push_back(32'h4000_0000);
        send(OP_FSQRT, 32'h4080_0000, 32'h0, 32'h0, 32'h0);
        wait_ov(base + 1);
        e = slog_at(0);
        chk("fsqrt_start", e.st, 4'b0100);
        chk("fsqrt_mode", e.md, 2'd1);

        // FDIV with a silent divider aborts after 64 wait cycles
        prep(); lat[2] = 0; base = ov_cnt;
        exp_q.push_back(NAN);
        send(OP_FDIV, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0);
        wait_ov(base + 1);
        chk("timeout_stall_cycles", stall_cnt, 66);
        chk("timeout_err_set", timeout_err, 1);
        prep(); lat[0] = 4; rsp[0] = 32'h4040_0000; base = ov_cnt;
        exp_q.push_back(32'h4040_0000);
        send(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0);
        wait_ov(base + 1);
        chk("timeout_err_sticky", timeout_err, 1);

        // Reset during WAIT abandons the op without a result strobe
        prep(); lat[1] = 0; base = ov_cnt;
        send(OP_FMUL, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        g_rst_n = 1'b0;
        @(posedge clk); #1;
        g_rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_stall", stall, 0);
        chk("midrst_res", res, NAN);
        chk("midrst_timeout_err", timeout_err, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_out_valid", ov_cnt, base);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
